// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues one memory read at a time and queues
// returned words with their addresses in a small FIFO toward decode.
`timescale 1ns/1ps
module ifetch_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_advance,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  // DEPTH is 2 or 4, so one or two pointer bits suffice.
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pending_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   buf_inst [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic          grant;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_req    = (state == IDLE) && (count < FULL) && !flush;
    grant      = mem_req && mem_gnt;
    pc_advance = grant;
    mem_addr   = pc;
    // Only a response to a live request in WAIT_RSP may enter the buffer.
    push       = (state == WAIT_RSP) && mem_rvalid && !flush;
    inst_valid = (count != '0);
    pop        = inst_valid && inst_ready && !flush;
    inst       = buf_inst[rd_ptr];
    inst_pc    = buf_pc[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            pending_pc <= pc;
            state      <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A flushed response still has to be absorbed before the next request.
          if (mem_rvalid)  state <= IDLE;
          else if (flush)  state <= DROP;
        end
        DROP: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_inst[wr_ptr] <= mem_rdata;
        buf_pc[wr_ptr]   <= pending_pc;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: transaction-level memory/buffer model feeding a
// scoreboard queue, with a separate monitor comparing every cycle.
`timescale 1ns/1ps
module tb_ifetch_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        pc_advance;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  ifetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_advance(pc_advance),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          outstanding = 1'b0;
  bit          poisoned = 1'b0;
  logic [31:0] out_pc = '0;
  int          lat_cnt = 0;
  bit          exp_req = 1'b0;
  event        mon_ev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the memory answers a granted request
  // 'lat' cycles later with whatever 'rd' is supplied in that cycle.
  task automatic do_cycle(input bit f, input bit rdy, input bit gnt, input int lat,
                          input logic [31:0] rd, input logic [31:0] pcv, input bit spur);
    ent_t e;
    @(negedge clk);
    flush      = f;
    inst_ready = rdy;
    mem_gnt    = gnt;
    pc         = pcv;
    mem_rdata  = rd;
    if (outstanding) begin
      lat_cnt--;
      mem_rvalid = (lat_cnt <= 0);
    end else begin
      mem_rvalid = spur;
    end
    #1;
    exp_req = !outstanding && (sb.size() < DEPTH) && !f;
    -> mon_ev;
    #2;
    if (outstanding && mem_rvalid) begin
      if (!poisoned && !f) begin
        e.pc  = out_pc;
        e.ins = rd;
        sb.push_back(e);
      end
      outstanding = 1'b0;
    end else if (outstanding && f) begin
      poisoned = 1'b1;
    end
    if (f) sb.delete();
    if (exp_req && gnt) begin
      outstanding = 1'b1;
      poisoned    = 1'b0;
      out_pc      = pcv;
      lat_cnt     = lat;
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_inst", inst, 32'd0);
    chk("async_rst_inst_pc", inst_pc, 32'd0);
    sb.delete();
    outstanding = 1'b0;
    poisoned    = 1'b0;
    #1 rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(mon_ev);
      #1;
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("pc_advance", 32'(pc_advance), 32'(exp_req && mem_gnt));
      chk("mem_addr", mem_addr, pc);
      chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("inst", inst, sb[0].ins);
        chk("inst_pc", inst_pc, sb[0].pc);
        if (inst_ready && !flush) void'(sb.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_inst_pc", inst_pc, 32'd0);
    #1 rst = 1'b0;

    // Single fetch, then consume it.
    do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0000, 0);
    do_cycle(0, 0, 0, 1, 32'h2008_0005, 32'h0000_0004, 0);
    do_cycle(0, 0, 0, 1, 32'h0, 32'h0000_0004, 0);
    do_cycle(0, 1, 0, 1, 32'h0, 32'h0000_0004, 0);

    // Fill the buffer with ready low, then hold and release one entry.
    do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0000, 0);
    do_cycle(0, 0, 1, 1, 32'h1111_0000, 32'h0000_0004, 0);
    do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0004, 0);
    do_cycle(0, 0, 1, 1, 32'h1111_0004, 32'h0000_0008, 0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0008, 0);
    do_cycle(0, 1, 0, 1, 32'h0, 32'h0000_0008, 0);
    do_cycle(0, 0, 0, 1, 32'h0, 32'h0000_0008, 0);
    do_cycle(1, 0, 0, 1, 32'h0, 32'h0000_0008, 0);

    // Flush while in flight: response arrives after the flush.
    do_cycle(0, 0, 1, 2, 32'h0, 32'h0000_0008, 0);
    do_cycle(1, 0, 1, 1, 32'h0, 32'h0000_0100, 0);
    do_cycle(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h0000_0100, 0);
    do_cycle(0, 1, 0, 1, 32'h0, 32'h0000_0100, 0);

    // Flush coincident with the response.
    do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0010, 0);
    do_cycle(1, 0, 0, 1, 32'h1234_5678, 32'h0000_0200, 0);
    do_cycle(0, 0, 0, 1, 32'h0, 32'h0000_0200, 0);

    // Push and pop together at count 1, across several pointer wraps.
    do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0300, 0);
    do_cycle(0, 0, 0, 1, 32'hA000_0000, 32'h0000_0304, 0);
    for (int i = 0; i < 6; i++) begin
      do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0304 + 32'(4 * i), 0);
      do_cycle(0, 1, 0, 1, 32'hA000_0001 + 32'(i), 32'h0, 0);
    end
    do_cycle(0, 1, 0, 1, 32'h0, 32'h0, 0);

    // Async reset while a request is outstanding; its late response is ignored.
    do_cycle(0, 0, 1, 1, 32'h0, 32'h0000_0400, 0);
    do_cycle(0, 0, 0, 1, 32'hB000_0000, 32'h0000_0404, 0);
    do_cycle(0, 0, 1, 3, 32'h0, 32'h0000_0404, 0);
    rst_pulse();
    do_cycle(0, 0, 0, 1, 32'hBAD0_BAD0, 32'h0000_0500, 1);
    do_cycle(0, 0, 0, 1, 32'h0, 32'h0000_0500, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      do_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) != 0, int'($urandom_range(1, 3)),
               $urandom, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) == 0);
      if (n % 700 == 699) rst_pulse();
    end

    do_cycle(0, 1, 0, 1, 32'h0, 32'h0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
